// File: rtl/bch_chien_corrector_if.sv
// Handshake and data bundle between the Berlekamp-Massey stage and the Chien corrector.
// The err_count/fail status signals exist only when BCH_CHIEN_STATUS_EN is defined.
interface bch_chien_corrector_if #(
    parameter int N = 15,
    parameter int K = 7,
    parameter int M = 4
);
    logic         valid_in;
    logic         ready_out;
    logic [M-1:0] lambda1;
    logic [M-1:0] lambda2;
    logic [N-1:0] codeword_in;
    logic         valid_out;
    logic [N-1:0] codeword_out;
    logic [K-1:0] data_out;
`ifdef BCH_CHIEN_STATUS_EN
    logic [1:0]   err_count;
    logic         fail;

    modport master (
        output valid_in, lambda1, lambda2, codeword_in,
        input  ready_out, valid_out, codeword_out, data_out, err_count, fail
    );
    modport slave (
        input  valid_in, lambda1, lambda2, codeword_in,
        output ready_out, valid_out, codeword_out, data_out, err_count, fail
    );
`else
    modport master (
        output valid_in, lambda1, lambda2, codeword_in,
        input  ready_out, valid_out, codeword_out, data_out
    );
    modport slave (
        input  valid_in, lambda1, lambda2, codeword_in,
        output ready_out, valid_out, codeword_out, data_out
    );
`endif
endinterface

// File: rtl/bch_chien_corrector.sv
// Serial Chien search and bit correction for BCH(15,7,t=2) over GF(2^4), p(x)=x^4+x+1.
// Define BCH_CHIEN_STATUS_EN to expose err_count/fail on the interface.
module bch_chien_corrector #(
    parameter int N = 15,
    parameter int K = 7,
    parameter int M = 4
) (
    input logic                  clk,
    input logic                  rst,
    bch_chien_corrector_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] K_LAST = 4'(N - 1);

    state_t       state, state_nxt;
    logic [M-1:0] t1, t2;
    logic [N-1:0] cw, orig, cw_out_q;
    logic [3:0]   k;
    logic [1:0]   roots, deg;
    logic         valid_out_q;
    logic         hit, fail_n;

    // Constant multipliers: v*alpha^-1 (= alpha^14) and v*alpha^-2 (= alpha^13) for x^4+x+1.
    function automatic logic [M-1:0] mul_ainv(input logic [M-1:0] v);
        return {v[0], v[3], v[2], v[1] ^ v[0]};
    endfunction

    function automatic logic [M-1:0] mul_ainv2(input logic [M-1:0] v);
        return {v[1] ^ v[0], v[0], v[3], v[2] ^ v[1] ^ v[0]};
    endfunction

    // Lambda(alpha^-k) = 1 + t1 + t2 is zero exactly when t1 ^ t2 equals the unit element.
    assign hit    = ((t1 ^ t2) == M'(1));
    assign fail_n = (roots != deg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid_in) state_nxt = SEARCH;
            SEARCH:  if (k == K_LAST)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BCH_CHIEN_STATUS_EN
    logic [1:0] err_count_q;
    logic       fail_q;
`endif

    // NOTE: the working registers are reset along with the outputs; an abort mid-search must leave nothing stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t1          <= '0;
            t2          <= '0;
            cw          <= '0;
            orig        <= '0;
            k           <= '0;
            roots       <= '0;
            deg         <= '0;
            cw_out_q    <= '0;
            valid_out_q <= 1'b0;
`ifdef BCH_CHIEN_STATUS_EN
            err_count_q <= '0;
            fail_q      <= 1'b0;
`endif
        end else begin
            valid_out_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        t1    <= bus.lambda1;
                        t2    <= bus.lambda2;
                        cw    <= bus.codeword_in;
                        orig  <= bus.codeword_in;
                        k     <= '0;
                        roots <= '0;
                        if (bus.lambda2 != '0)      deg <= 2'd2;
                        else if (bus.lambda1 != '0) deg <= 2'd1;
                        else                        deg <= 2'd0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        cw[k] <= ~cw[k];
                        if (roots != 2'd3) roots <= roots + 2'd1;
                    end
                    t1 <= mul_ainv(t1);
                    t2 <= mul_ainv2(t2);
                    k  <= k + 4'd1;
                end
                DONE: begin
                    cw_out_q    <= fail_n ? orig : cw;
                    valid_out_q <= 1'b1;
`ifdef BCH_CHIEN_STATUS_EN
                    err_count_q <= fail_n ? 2'd0 : roots;
                    fail_q      <= fail_n;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_out    = (state == IDLE);
    assign bus.valid_out    = valid_out_q;
    assign bus.codeword_out = cw_out_q;
    assign bus.data_out     = cw_out_q[N-1:N-K];
`ifdef BCH_CHIEN_STATUS_EN
    assign bus.err_count    = err_count_q;
    assign bus.fail         = fail_q;
`endif

endmodule

// File: tb/tb_bch_chien_corrector.sv
// Self-checking bench for bch_chien_corrector: directed cases, back-to-back, mid-search reset
// and randomized words against a log/antilog GF(16) polynomial-evaluation model.
module tb_bch_chien_corrector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bch_chien_corrector_if bus ();

    bch_chien_corrector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int gexp[15];
    int glog[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Evaluate Lambda at every alpha^-k directly; correct only if the root count equals deg(Lambda).
    task automatic model(input logic [14:0] c, input logic [3:0] a, input logic [3:0] b,
                         output logic [14:0] ecw, output logic [1:0] ecnt, output bit efail);
        logic [14:0] fixed;
        int roots, deg, x, v;
        fixed = c;
        roots = 0;
        for (int j = 0; j < 15; j++) begin
            x = gexp[(15 - j) % 15];
            v = 1 ^ gmul(int'(a), x) ^ gmul(int'(b), gmul(x, x));
            if (v == 0) begin
                fixed[j] = ~fixed[j];
                roots++;
            end
        end
        deg   = (b != 0) ? 2 : (a != 0) ? 1 : 0;
        efail = (roots != deg);
        ecw   = efail ? c : fixed;
        ecnt  = efail ? 2'd0 : 2'(roots);
    endtask

    task automatic run_word(input string tag, input logic [14:0] c, input logic [3:0] a,
                            input logic [3:0] b, input bit hold);
        logic [14:0] ecw;
        logic [1:0]  ecnt;
        bit          efail, seen;
        int          cyc, low, waitc;
        model(c, a, b, ecw, ecnt, efail);
        bus.valid_in    = 1'b1;
        bus.codeword_in = c;
        bus.lambda1     = a;
        bus.lambda2     = b;
        waitc = 0;
        while (!bus.ready_out && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, "_ready_before"}, 32'(bus.ready_out), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.valid_in = 1'b0;
        check({tag, "_vout_after_accept"}, 32'(bus.valid_out), 32'd0);
        cyc  = 0;
        low  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (!bus.ready_out) low++;
            @(posedge clk); #1;
            cyc++;
            if (bus.valid_out) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd16);
        check({tag, "_ready_low"}, 32'(low), 32'd16);
        check({tag, "_ready_at_vout"}, 32'(bus.ready_out), 32'd1);
        check({tag, "_cw_out"}, 32'(bus.codeword_out), 32'(ecw));
        check({tag, "_data_out"}, 32'(bus.data_out), 32'(ecw[14:8]));
`ifdef BCH_CHIEN_STATUS_EN
        check({tag, "_err_count"}, 32'(bus.err_count), 32'(ecnt));
        check({tag, "_fail"}, 32'(bus.fail), 32'(efail));
`else
        if (ecnt > 2'd2 && efail) check({tag, "_model_range"}, 32'(ecnt), 32'd0);
`endif
    endtask

    initial begin
        int v;
        logic [14:0] c;
        logic [3:0]  a, b;
        int          e1, e2, kind, pulses;

        v = 1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        glog[0] = 0;

        bus.valid_in    = 1'b0;
        bus.codeword_in = '0;
        bus.lambda1     = '0;
        bus.lambda2     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_cw_out", 32'(bus.codeword_out), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_ready", 32'(bus.ready_out), 32'd1);
`ifdef BCH_CHIEN_STATUS_EN
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_fail", 32'(bus.fail), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_word("two_err", 15'h0088, 4'b0011, 4'b0111, 1'b0);
        check("two_err_cw_zero", 32'(bus.codeword_out), 32'h0);
        @(posedge clk); #1;
        check("pulse_one_cycle", 32'(bus.valid_out), 32'd0);
        run_word("one_err", 15'h0001, 4'b0001, 4'b0000, 1'b0);
        run_word("no_err", 15'h4A31, 4'b0000, 4'b0000, 1'b0);
        check("no_err_passthru", 32'(bus.codeword_out), 32'h4A31);
        run_word("dbl_root", 15'h0F0F, 4'b0000, 4'b0001, 1'b0);
        check("dbl_root_unmodified", 32'(bus.codeword_out), 32'h0F0F);

        // Back-to-back: valid_in stays high across three words.
        run_word("b2b0", 15'h1234, 4'(gexp[2] ^ gexp[9]), 4'(gexp[11]), 1'b1);
        run_word("b2b1", 15'h7FFF, 4'(gexp[14]), 4'b0000, 1'b1);
        run_word("b2b2", 15'h2AAA, 4'b0000, 4'b0000, 1'b0);

        // Reset at search step k=7 of the two-error case.
        bus.valid_in    = 1'b1;
        bus.codeword_in = 15'h0088;
        bus.lambda1     = 4'b0011;
        bus.lambda2     = 4'b0111;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_valid_out", 32'(bus.valid_out), 32'd0);
        check("abort_cw_out", 32'(bus.codeword_out), 32'd0);
        check("abort_ready", 32'(bus.ready_out), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.valid_out) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        run_word("resubmit", 15'h0088, 4'b0011, 4'b0111, 1'b0);

        for (int n = 0; n < 12; n++) begin
            c    = 15'($urandom);
            kind = int'($urandom_range(0, 3));
            e1   = int'($urandom_range(0, 14));
            e2   = (e1 + 1 + int'($urandom_range(0, 13))) % 15;
            case (kind)
                0: begin a = 4'd0; b = 4'd0; end
                1: begin a = 4'(gexp[e1]); b = 4'd0; end
                2: begin a = 4'(gexp[e1] ^ gexp[e2]); b = 4'(gexp[(e1 + e2) % 15]); end
                default: begin a = 4'($urandom); b = 4'($urandom); end
            endcase
            run_word($sformatf("rand%0d", n), c, a, b, 1'($urandom_range(0, 1)));
        end
        bus.valid_in = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
